// File: rtl/fadd_share_arb_if.sv
// Handshake and data bundle around fadd_share_arb: two requester ports,
// two response ports and the link to the shared FP add/sub unit.
// slave  = arbiter side, master = environment (requesters, unit, consumers).
interface fadd_share_arb_if;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;

    logic [31:0] fu_a, fu_b;
    logic        fu_sub, fu_valid, fu_en;
    logic [31:0] fu_res;
    logic [4:0]  fu_flags;

    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_res;
    logic [4:0]  rsp0_flags;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_res;
    logic [4:0]  rsp1_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req0_ready, req1_ready,
        output fu_a, fu_b, fu_sub, fu_valid, fu_en,
        input  fu_res, fu_flags,
        output rsp0_valid, rsp0_res, rsp0_flags,
        output rsp1_valid, rsp1_res, rsp1_flags,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req0_ready, req1_ready,
        input  fu_a, fu_b, fu_sub, fu_valid, fu_en,
        output fu_res, fu_flags,
        input  rsp0_valid, rsp0_res, rsp0_flags,
        input  rsp1_valid, rsp1_res, rsp1_flags,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/fadd_share_arb.sv
// Two-requester arbiter in front of one pipelined FP add/sub unit.
// A tag pipeline ({valid,id} per unit stage) tracks who owns each result;
// the whole unit stalls while the head result waits on its consumer.
// Build option: FADD_ARB_FIXED_PRIO_EN -> requester 0 always wins, no pointer;
// otherwise round-robin with a 1-bit priority pointer.
module fadd_share_arb #(
    parameter int LAT = 3
) (
    input logic             clk,
    input logic             rst_n,
    fadd_share_arb_if.slave bus
);
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q,  tag_id_d;
    logic           head_vld, head_id, head_rdy, fu_en;
    logic           rdy0, rdy1, gnt0, gnt1, issue;
`ifndef FADD_ARB_FIXED_PRIO_EN
    logic           ptr_q, ptr_d;
`endif

    assign head_vld = tag_vld_q[LAT-1];
    assign head_id  = tag_id_q[LAT-1];
    assign head_rdy = head_id ? bus.rsp1_ready : bus.rsp0_ready;
    // Unit advances unless the head result is held by its consumer.
    assign fu_en    = !(head_vld && !head_rdy);

    // Ready looks only at the other requester's valid; reset forces it low.
    always_comb begin
`ifdef FADD_ARB_FIXED_PRIO_EN
        rdy0 = fu_en && rst_n;
        rdy1 = fu_en && rst_n && !bus.req0_valid;
`else
        rdy0 = fu_en && rst_n && (!ptr_q || !bus.req1_valid);
        rdy1 = fu_en && rst_n && ( ptr_q || !bus.req0_valid);
`endif
    end

    assign gnt0  = bus.req0_valid && rdy0;
    assign gnt1  = bus.req1_valid && rdy1;
    assign issue = gnt0 || gnt1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.fu_en      = fu_en;
    assign bus.fu_valid   = issue;
    assign bus.fu_a       = gnt0 ? bus.req0_a   : (gnt1 ? bus.req1_a   : 32'h0);
    assign bus.fu_b       = gnt0 ? bus.req0_b   : (gnt1 ? bus.req1_b   : 32'h0);
    assign bus.fu_sub     = gnt0 ? bus.req0_sub : (gnt1 ? bus.req1_sub : 1'b0);

    // Head slot steers the unit result to its owner; the other port reads 0.
    assign bus.rsp0_valid = head_vld && !head_id;
    assign bus.rsp1_valid = head_vld &&  head_id;
    assign bus.rsp0_res   = bus.rsp0_valid ? bus.fu_res   : 32'h0;
    assign bus.rsp0_flags = bus.rsp0_valid ? bus.fu_flags : 5'h0;
    assign bus.rsp1_res   = bus.rsp1_valid ? bus.fu_res   : 32'h0;
    assign bus.rsp1_flags = bus.rsp1_valid ? bus.fu_flags : 5'h0;

    // Tag pipeline shifts in lock-step with the unit; slot 0 takes the issue.
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        if (fu_en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
            tag_vld_d[0] = issue;
            tag_id_d[0]  = gnt1;
        end
    end

`ifndef FADD_ARB_FIXED_PRIO_EN
    // After any grant the pointer prefers the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) ptr_d = !gnt1;
    end
`endif

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
`ifndef FADD_ARB_FIXED_PRIO_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
`ifndef FADD_ARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_fadd_share_arb.sv
// Bench for fadd_share_arb: LAT=3 instance checked every cycle against a
// queue-based model (in-flight ops with stage counters), plus a LAT=1
// instance for single-requester streaming. The shared unit is emulated by
// a pipeline computing res = a + b + sub, flags = {sub, a[3:0]^b[3:0]}.
module tb_fadd_share_arb;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fadd_share_arb_if i3 ();
    fadd_share_arb_if i1 ();

    fadd_share_arb #(.LAT(LAT3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    fadd_share_arb #(.LAT(1))    dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b, input logic s);
        return a + b + {31'b0, s};
    endfunction
    function automatic logic [4:0] ffl(input logic [31:0] a, input logic [31:0] b, input logic s);
        return {s, a[3:0] ^ b[3:0]};
    endfunction

    // Emulated shared units
    logic [31:0] p3r [LAT3];
    logic [4:0]  p3f [LAT3];
    logic [31:0] p1r;
    logic [4:0]  p1f;
    always @(posedge clk) begin
        if (i3.fu_en) begin
            for (int i = LAT3 - 1; i > 0; i--) begin
                p3r[i] <= p3r[i-1];
                p3f[i] <= p3f[i-1];
            end
            p3r[0] <= fres(i3.fu_a, i3.fu_b, i3.fu_sub);
            p3f[0] <= ffl(i3.fu_a, i3.fu_b, i3.fu_sub);
        end
        if (i1.fu_en) begin
            p1r <= fres(i1.fu_a, i1.fu_b, i1.fu_sub);
            p1f <= ffl(i1.fu_a, i1.fu_b, i1.fu_sub);
        end
    end
    assign i3.fu_res   = p3r[LAT3-1];
    assign i3.fu_flags = p3f[LAT3-1];
    assign i1.fu_res   = p1r;
    assign i1.fu_flags = p1f;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of in-flight ops; adv counts unit advances.
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [4:0]  fl;
        int          adv;
    } item_t;
    item_t q[$];
    bit    m_ptr;
    bit    l1_v;
    logic [31:0] l1_r;
    logic [4:0]  l1_f;

    // Observations captured each cycle for directed checks
    int          obs_gnt;
    logic        obs_fu_valid, obs_fu_en, obs_rdy0, obs_rdy1, obs_r0v, obs_r1v, obs1_v;
    logic [31:0] obs_r0res, obs_r1res, obs1_res;
    logic [4:0]  obs_r0fl, obs1_fl;

    task automatic model_step();
        bit head, hid, en, hs0, hs1;
        int g;
        item_t it;
        if (!rst_n) begin
            chk("rst_fu_en", i3.fu_en, 1);
            chk("rst_ready", {i3.req0_ready, i3.req1_ready}, 0);
            chk("rst_fu", {i3.fu_valid, i3.fu_sub, i3.fu_a ^ i3.fu_b}, 0);
            chk("rst_rsp_v", {i3.rsp0_valid, i3.rsp1_valid}, 0);
            chk("rst_rsp_d", i3.rsp0_res | i3.rsp1_res | {27'b0, i3.rsp0_flags | i3.rsp1_flags}, 0);
            q.delete();
            m_ptr = 0;
            return;
        end
        head = (q.size() > 0) && (q[0].adv == LAT3);
        hid  = head ? q[0].id : 1'b0;
        en   = !(head && !(hid ? i3.rsp1_ready : i3.rsp0_ready));
        g = -1;
        if (en) begin
`ifdef FADD_ARB_FIXED_PRIO_EN
            if (i3.req0_valid) g = 0; else if (i3.req1_valid) g = 1;
`else
            if (m_ptr == 0) begin
                if (i3.req0_valid) g = 0; else if (i3.req1_valid) g = 1;
            end else begin
                if (i3.req1_valid) g = 1; else if (i3.req0_valid) g = 0;
            end
`endif
        end
        hs0 = i3.req0_valid && i3.req0_ready;
        hs1 = i3.req1_valid && i3.req1_ready;
        chk("fu_en", i3.fu_en, en);
        chk("grant0", hs0, g == 0);
        chk("grant1", hs1, g == 1);
        chk("fu_valid", i3.fu_valid, g >= 0);
        chk("fu_a", i3.fu_a, g == 0 ? i3.req0_a : (g == 1 ? i3.req1_a : 32'h0));
        chk("fu_b", i3.fu_b, g == 0 ? i3.req0_b : (g == 1 ? i3.req1_b : 32'h0));
        chk("fu_sub", i3.fu_sub, g == 0 ? i3.req0_sub : (g == 1 ? i3.req1_sub : 1'b0));
        if (!en) chk("stall_ready", {i3.req0_ready, i3.req1_ready}, 0);
        chk("rsp0_valid", i3.rsp0_valid, head && !hid);
        chk("rsp1_valid", i3.rsp1_valid, head && hid);
        chk("rsp0_res", i3.rsp0_res, (head && !hid) ? q[0].res : 32'h0);
        chk("rsp1_res", i3.rsp1_res, (head && hid) ? q[0].res : 32'h0);
        chk("rsp0_flags", i3.rsp0_flags, (head && !hid) ? q[0].fl : 5'h0);
        chk("rsp1_flags", i3.rsp1_flags, (head && hid) ? q[0].fl : 5'h0);
        if (en) begin
            if (head) void'(q.pop_front());
            foreach (q[i]) q[i].adv++;
            if (g == 0) begin
                it.id = 0; it.res = fres(i3.req0_a, i3.req0_b, i3.req0_sub);
                it.fl = ffl(i3.req0_a, i3.req0_b, i3.req0_sub); it.adv = 1;
                q.push_back(it);
            end else if (g == 1) begin
                it.id = 1; it.res = fres(i3.req1_a, i3.req1_b, i3.req1_sub);
                it.fl = ffl(i3.req1_a, i3.req1_b, i3.req1_sub); it.adv = 1;
                q.push_back(it);
            end
`ifndef FADD_ARB_FIXED_PRIO_EN
            if (g >= 0) m_ptr = (g == 0);
`endif
        end
    endtask

    // LAT=1 instance: requester 0 only, consumer always ready.
    task automatic model1_step();
        if (!rst_n) begin
            chk("l1_rst_v", i1.rsp0_valid, 0);
            l1_v = 0;
            return;
        end
        chk("l1_fu_valid", i1.fu_valid, i1.req0_valid);
        chk("l1_rsp_v", i1.rsp0_valid, l1_v);
        if (l1_v) begin
            chk("l1_res", i1.rsp0_res, l1_r);
            chk("l1_flags", i1.rsp0_flags, l1_f);
        end
        l1_v = i1.req0_valid;
        l1_r = fres(i1.req0_a, i1.req0_b, i1.req0_sub);
        l1_f = ffl(i1.req0_a, i1.req0_b, i1.req0_sub);
    endtask

    task automatic tick();
        @(negedge clk);
        obs_gnt      = (i3.req1_valid && i3.req1_ready) ? 1 : ((i3.req0_valid && i3.req0_ready) ? 0 : -1);
        obs_fu_valid = i3.fu_valid;
        obs_fu_en    = i3.fu_en;
        obs_rdy0     = i3.req0_ready;
        obs_rdy1     = i3.req1_ready;
        obs_r0v      = i3.rsp0_valid;
        obs_r1v      = i3.rsp1_valid;
        obs_r0res    = i3.rsp0_res;
        obs_r0fl     = i3.rsp0_flags;
        obs_r1res    = i3.rsp1_res;
        obs1_v       = i1.rsp0_valid;
        obs1_res     = i1.rsp0_res;
        obs1_fl      = i1.rsp0_flags;
        model_step();
        model1_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_req0();
        i3.req0_a = $urandom; i3.req0_b = $urandom; i3.req0_sub = 1'($urandom_range(0, 1));
    endtask
    task automatic rnd_req1();
        i3.req1_a = $urandom; i3.req1_b = $urandom; i3.req1_sub = 1'($urandom_range(0, 1));
    endtask
    task automatic do_reset();
        rst_n = 0; tick(); tick(); rst_n = 1; tick();
    endtask
    task automatic drain();
        i3.req0_valid = 0; i3.req1_valid = 0; i3.rsp0_ready = 1; i3.rsp1_ready = 1;
        for (int k = 0; k < LAT3 + 4; k++) tick();
    endtask

    initial begin
        logic [31:0] sa, sb;
        logic        ss;
        int          nrsp, first_c, last_c, ngnt;

        rst_n = 0;
        i3.req0_valid = 0; i3.req0_a = 0; i3.req0_b = 0; i3.req0_sub = 0;
        i3.req1_valid = 0; i3.req1_a = 0; i3.req1_b = 0; i3.req1_sub = 0;
        i3.rsp0_ready = 1; i3.rsp1_ready = 1;
        i1.req0_valid = 0; i1.req0_a = 0; i1.req0_b = 0; i1.req0_sub = 0;
        i1.req1_valid = 0; i1.req1_a = 0; i1.req1_b = 0; i1.req1_sub = 0;
        i1.rsp0_ready = 1; i1.rsp1_ready = 1;
        for (int i = 0; i < LAT3; i++) begin p3r[i] = 0; p3f[i] = 0; end
        p1r = 0; p1f = 0;
        m_ptr = 0; l1_v = 0; l1_r = 0; l1_f = 0;
        @(posedge clk); #1;

        // Reset state
        tick();
        chk("reset_fu_en", obs_fu_en, 1);
        chk("reset_rsp_v", {obs_r0v, obs_r1v}, 0);
        rst_n = 1; tick();

        // Single op from requester 0: issue at cycle 0, response at cycle 3
        i3.req0_valid = 1; i3.req0_a = 32'h3F800000; i3.req0_b = 32'h40000000; i3.req0_sub = 0;
        tick();
        chk("c0_fu_valid", obs_fu_valid, 1);
        chk("c0_grant", obs_gnt, 0);
        i3.req0_valid = 0;
        tick(); chk("c1_rsp0_v", obs_r0v, 0);
        tick(); chk("c2_rsp0_v", obs_r0v, 0);
        tick();
        chk("c3_rsp0_v", obs_r0v, 1);
        chk("c3_rsp0_res", obs_r0res, 32'h7F800000);
        chk("c3_rsp0_flags", obs_r0fl, 5'h00);
        drain();

        // Both requesters continuously valid after reset
        do_reset();
        i3.req0_valid = 1; i3.req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            rnd_req0(); rnd_req1();
            tick();
`ifdef FADD_ARB_FIXED_PRIO_EN
            chk("alt_grant", obs_gnt, 0);
`else
            chk("alt_grant", obs_gnt, k % 2);
`endif
        end
        drain();

        // Head owned by requester 1 held for 4 cycles
        sa = 32'h0000_1234; sb = 32'h0000_0F0F; ss = 1;
        i3.rsp1_ready = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                i3.req1_valid = 1; i3.req1_a = sa; i3.req1_b = sb; i3.req1_sub = ss;
                i3.req0_valid = 0;
            end else begin
                i3.req1_valid = 0; i3.req0_valid = 1; rnd_req0();
            end
            if (k == 7) i3.rsp1_ready = 1;
            tick();
            if (k >= 3 && k <= 6) begin
                chk("stall_fu_en", obs_fu_en, 0);
                chk("stall_rdy", {obs_rdy0, obs_rdy1}, 0);
                chk("stall_rsp1_v", obs_r1v, 1);
                chk("stall_rsp1_res", obs_r1res, fres(sa, sb, ss));
            end
        end
        chk("stall_release_en", obs_fu_en, 1);
        drain();

        // 8 back-to-back ops complete in 8+LAT cycles
        nrsp = 0; first_c = -1; last_c = -1; ngnt = 0;
        for (int k = 0; k < 8 + LAT3; k++) begin
            i3.req0_valid = (k < 8); rnd_req0();
            tick();
            if (obs_gnt == 0) ngnt++;
            if (obs_r0v) begin
                nrsp++;
                if (first_c < 0) first_c = k;
                last_c = k;
            end
        end
        chk("b2b_grants", ngnt, 8);
        chk("b2b_rsps", nrsp, 8);
        chk("b2b_first", first_c, LAT3);
        chk("b2b_last", last_c, 7 + LAT3);
        drain();

        // Reset with 3 ops in flight
        i3.req0_valid = 1;
        for (int k = 0; k < 3; k++) begin rnd_req0(); tick(); end
        i3.req0_valid = 0;
        #1;
        chk("pre_rst_rsp0_v", i3.rsp0_valid, 1);
        rst_n = 0;
        #1;
        chk("async_rsp0_v", i3.rsp0_valid, 0);
        chk("async_fu_en", i3.fu_en, 1);
        chk("async_rdy", {i3.req0_ready, i3.req1_ready}, 0);
        tick(); tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_rsp_v", {obs_r0v, obs_r1v}, 0);
        end

        // Randomized traffic with random consumer back-pressure
        for (int k = 0; k < 3000; k++) begin
            i3.req0_valid = ($urandom_range(0, 99) < 60);
            i3.req1_valid = ($urandom_range(0, 99) < 60);
            rnd_req0(); rnd_req1();
            i3.rsp0_ready = ($urandom_range(0, 99) < 70);
            i3.rsp1_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        drain();
        chk("all_returned", q.size(), 0);

        // LAT=1 single requester streaming
        i1.req0_valid = 1; i1.req0_a = 32'd1; i1.req0_b = 32'd2; i1.req0_sub = 1;
        tick();
        nrsp = 0;
        for (int k = 0; k < 20; k++) begin
            i1.req0_a = $urandom; i1.req0_b = $urandom; i1.req0_sub = 1'($urandom_range(0, 1));
            tick();
            if (k == 0) begin
                chk("l1_first_res", obs1_res, 32'd4);
                chk("l1_first_flags", obs1_fl, 5'b10011);
            end
            if (obs1_v) nrsp++;
        end
        i1.req0_valid = 0;
        tick();
        if (obs1_v) nrsp++;
        tick();
        chk("l1_rsp_count", nrsp, 21);
        chk("l1_idle", obs1_v, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fadd_share_arb.md
FADD_SHARE_ARB -- requirements
Module: fadd_share_arb

Interface
REQ-001 SHALL have parameter LAT, default 3: pipeline depth of the shared FP add/sub unit; legal range 1..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports reqN_valid / reqN_ready  input / output  1 each, for N = 0 and 1: per-requester operation handshake.
REQ-005 SHALL have ports reqN_a / reqN_b  input  32 each: IEEE-754 single-precision operands.
REQ-006 SHALL have port reqN_sub  input  1: 1 = subtract, 0 = add.
REQ-007 SHALL have ports fu_a / fu_b  output  32 each, and fu_sub  output  1: operands and add_sub select sent to the shared unit.
REQ-008 SHALL have ports fu_valid  output  1 (issue this cycle) and fu_en  output  1 (advance the unit pipeline).
REQ-009 SHALL have ports fu_res  input  32 and fu_flags  input  5: unit result and flags aligned with tag slot LAT-1.
REQ-010 SHALL have ports rspN_valid / rspN_ready  output / input  1 each: per-requester response handshake.
REQ-011 SHALL have ports rspN_res  output  32 and rspN_flags  output  5: per-requester response data.

Function
REQ-012 SHALL keep a tag pipeline of LAT slots, each holding {valid, id}; slot 0 loads on issue; slot LAT-1 is the head.
REQ-013 SHALL drive fu_en = !(head.valid && !rsp[head.id]_ready).
REQ-014 SHALL shift all tag slots by one and load slot 0 with {fu_valid, grant id} on every edge where fu_en = 1; with fu_en = 0 all slots hold.
REQ-015 SHALL grant at most one requester per cycle, and only when fu_en = 1.
REQ-016 SHALL assert reqN_ready only for the granted requester; reqN_ready SHALL be combinational and SHALL NOT depend on reqN_valid of the same requester.
REQ-017 SHALL drive fu_valid = reqN_valid && reqN_ready, and drive fu_a, fu_b and fu_sub from the granted requester; when nothing is granted these outputs SHALL be 0.
REQ-018 SHALL arbitrate round-robin: a 1-bit priority pointer names the preferred requester, and after each grant it points to the other requester.
REQ-019 SHALL drive rspN_valid = head.valid && head.id == N, with rspN_res = fu_res and rspN_flags = fu_flags; the non-selected response port SHALL output 0 data.
REQ-020 SHALL give latency exactly LAT cycles from request handshake to rspN_valid when no stall occurs.
REQ-021 SHALL sustain throughput of one operation per cycle when the head is empty or the head response is accepted.
REQ-022 SHALL, when head response is accepted and a new request is issued in the same cycle, perform both in that single edge.
REQ-023 SHALL preserve issue order: responses are returned in issue order per requester and globally.
REQ-024 SHALL never drop or duplicate an operation under any stall pattern.

Reset
REQ-025 SHALL, while rst_n = 0, clear all tag valids and set the priority pointer to 0 immediately (asynchronous).
REQ-026 SHALL hold all outputs at 0 during reset, except fu_en = 1.
REQ-027 SHALL discard all in-flight operations when reset is asserted mid-operation, with no response emitted after reset release.

Configuration
REQ-028 SHALL, when macro FADD_ARB_FIXED_PRIO_EN is defined, use fixed priority (requester 0 always wins) and remove the priority pointer.
REQ-029 SHALL, when FADD_ARB_FIXED_PRIO_EN is undefined, use the round-robin of REQ-018.

Verification
REQ-030 SHALL cover: LAT=3; req0 valid with a=0x3F800000, b=0x40000000, sub=0 at cycle 0 -> fu_valid at cycle 0, rsp0_valid at cycle 3 carrying fu_res.
REQ-031 SHALL cover: both requesters valid continuously, rsp ready = 1 -> grants alternate 0,1,0,1; with FADD_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
REQ-032 SHALL cover: rsp1_ready = 0 for 4 cycles while head.id = 1 -> fu_en = 0, req0_ready = req1_ready = 0, rsp1 data stable; release -> order preserved.
REQ-033 SHALL cover: head accepted and new issue in the same cycle -> no bubble, 8 back-to-back operations complete in 8+LAT cycles.
REQ-034 SHALL cover: rst_n pulled low with 3 operations in flight -> outputs cleared immediately, no rsp*_valid after release until a new request.
REQ-035 SHALL cover: LAT=1 with a single requester streaming -> one response per cycle, each 1 cycle after its request.
